// File: rtl/dram_cmd_scheduler_if.sv
// Request, command and status bundle around the DDR3 command scheduler.
// master: scheduler side; slave: request sources plus the command state machine.
interface dram_cmd_scheduler_if;
    logic       wr_req;
    logic       rd_req;
    logic       sm_idle;
    logic       wr_ack;
    logic       rd_ack;
    logic       REF;
    logic       WRITE;
    logic       READ;
    logic [3:0] ref_pending;
    logic [1:0] sched_state;
    logic       timeout_err;
    logic       ref_overflow;

    modport master (
        input  wr_req, rd_req, sm_idle,
        output wr_ack, rd_ack, REF, WRITE, READ, ref_pending, sched_state, timeout_err,
               ref_overflow
    );

    modport slave (
        output wr_req, rd_req, sm_idle,
        input  wr_ack, rd_ack, REF, WRITE, READ, ref_pending, sched_state, timeout_err,
               ref_overflow
    );
endinterface

// File: rtl/dram_cmd_scheduler.sv
// Refresh timer, postponed-refresh bookkeeping and wr/rd arbitration feeding the DDR3 command FSM.
// Define REF_POSTPONE_EN to let user traffic run ahead of refresh until MAX_POSTPONE are owed.
module dram_cmd_scheduler #(
    parameter int unsigned REFI_CYCLES  = 1560,
    parameter int unsigned MAX_POSTPONE = 8,
    parameter int unsigned CMD_TIMEOUT  = 255
) (
    input logic                  CLK,
    input logic                  Reset_input,
    dram_cmd_scheduler_if.master bus
);
    localparam int unsigned RefiW = (REFI_CYCLES > 1) ? $clog2(REFI_CYCLES) : 1;
    localparam int unsigned TmoW  = (CMD_TIMEOUT > 1) ? $clog2(CMD_TIMEOUT) : 1;

    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StIssue     = 2'd1;
    localparam logic [1:0] StWaitStart = 2'd2;
    localparam logic [1:0] StWaitDone  = 2'd3;

    localparam logic [1:0] CmdRef = 2'd0;
    localparam logic [1:0] CmdWr  = 2'd1;
    localparam logic [1:0] CmdRd  = 2'd2;

    localparam logic [3:0]       MaxPend  = 4'(MAX_POSTPONE);
    localparam logic [RefiW-1:0] RefiLast = RefiW'(REFI_CYCLES - 1);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(CMD_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       cmd_q, cmd_d;
    logic             rr_q, rr_d;  // 0: write is preferred on the next contended grant
    logic [RefiW-1:0] refi_q, refi_d;
    logic [3:0]       pend_q, pend_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic             tmo_err_q, tmo_err_d;
    logic             ovf_q, ovf_d;
    logic             tick, ref_done, force_ref, user_req;

    assign tick     = (refi_q == RefiLast);
    assign refi_d   = tick ? '0 : refi_q + 1'b1;
    assign ref_done = (state_q == StWaitDone) && bus.sm_idle && (cmd_q == CmdRef);
    assign user_req = bus.wr_req | bus.rd_req;

`ifdef REF_POSTPONE_EN
    assign force_ref = (pend_q >= MaxPend);
`else
    assign force_ref = (pend_q != 4'd0);
`endif

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (tick && !ref_done) begin
            if (pend_q < MaxPend) pend_d = pend_q + 4'd1;
        end else if (ref_done && !tick) begin
            pend_d = pend_q - 4'd1;
        end
`ifdef REF_POSTPONE_EN
        if (tick && (pend_q == MaxPend)) ovf_d = 1'b1;
`else
        if (tick && (pend_d > 4'd1)) ovf_d = 1'b1;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        rr_d      = rr_q;
        tmo_d     = tmo_q;
        tmo_err_d = tmo_err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.sm_idle) begin
                    if (force_ref) begin
                        cmd_d   = CmdRef;
                        state_d = StIssue;
                    end else if (user_req) begin
                        // A lone requester wins; contention is settled by the pointer.
                        cmd_d   = (bus.wr_req && (!bus.rd_req || !rr_q)) ? CmdWr : CmdRd;
                        rr_d    = ~rr_q;
                        state_d = StIssue;
                    end else if (pend_q != 4'd0) begin
                        cmd_d   = CmdRef;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                tmo_d   = '0;
                state_d = StWaitStart;
            end
            StWaitStart: begin
                if (!bus.sm_idle) begin
                    state_d = StWaitDone;
                end else if (tmo_q == TmoLast) begin
                    tmo_err_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (bus.sm_idle) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset_input) begin
        if (Reset_input) begin
            state_q   <= StIdle;
            cmd_q     <= CmdRef;
            rr_q      <= 1'b0;
            refi_q    <= '0;
            pend_q    <= 4'd0;
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            rr_q      <= rr_d;
            refi_q    <= refi_d;
            pend_q    <= pend_d;
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.REF          = (state_q == StIssue) && (cmd_q == CmdRef);
    assign bus.WRITE        = (state_q == StIssue) && (cmd_q == CmdWr);
    assign bus.READ         = (state_q == StIssue) && (cmd_q == CmdRd);
    assign bus.wr_ack       = (state_q == StWaitDone) && bus.sm_idle && (cmd_q == CmdWr);
    assign bus.rd_ack       = (state_q == StWaitDone) && bus.sm_idle && (cmd_q == CmdRd);
    assign bus.ref_pending  = pend_q;
    assign bus.sched_state  = state_q;
    assign bus.timeout_err  = tmo_err_q;
    assign bus.ref_overflow = ovf_q;
endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Randomized bench for dram_cmd_scheduler against a transaction-level reference model.
module tb_dram_cmd_scheduler;
    localparam int Refi  = 100;
    localparam int MaxPp = 8;
    localparam int Tmo   = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dram_cmd_scheduler_if bus ();

    dram_cmd_scheduler #(
        .REFI_CYCLES (Refi),
        .MAX_POSTPONE(MaxPp),
        .CMD_TIMEOUT (Tmo)
    ) dut (
        .CLK        (clk),
        .Reset_input(rst),
        .bus        (bus)
    );

    int total = 0;
    int bad = 0;

    // Reference model: m_cmd 0 none, 1 ref, 2 write, 3 read; m_age 0 in the pulse cycle.
    int m_cyc, m_pend, m_cmd, m_age, m_waited;
    bit m_started, m_rr_rd, m_terr, m_ovf;

    // Environment (command FSM and requesters).
    int busy;
    bit auto_drop, stuck_wr, rand_busy;
    bit seen_pulse, seen_write, seen_wr_ack, seen_rd_ack;

    // Observations of the DUT.
    int n_ref, n_wr, n_rd, n_wack, n_rack;
    int first_ref_cyc, abs_cyc, last_pulse_abs, last_write_abs, err_rise_abs, maxp;
    bit prev_err, track_max;
    int ulog[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int pick(input bit wr, input bit rd, input int pend, input bit rr_rd);
        bit force_ref;
`ifdef REF_POSTPONE_EN
        force_ref = (pend >= MaxPp);
`else
        force_ref = (pend > 0);
`endif
        if (force_ref) return 1;
        if (wr && rd) return rr_rd ? 3 : 2;
        if (wr) return 2;
        if (rd) return 3;
        if (pend > 0) return 1;
        return 0;
    endfunction

    task automatic sample_and_check();
        logic [13:0] act, exp;
        int st, nxt, npend;
        bit tick, issue, done, wr, rd, idle;
        act = {bus.REF, bus.WRITE, bus.READ, bus.wr_ack, bus.rd_ack, bus.ref_pending,
               bus.sched_state, bus.timeout_err, bus.ref_overflow};
        seen_pulse  = bus.REF | bus.WRITE | bus.READ;
        seen_write  = bus.WRITE;
        seen_wr_ack = bus.wr_ack;
        seen_rd_ack = bus.rd_ack;
        abs_cyc++;
        if (rst) begin
            m_cyc = 0; m_pend = 0; m_cmd = 0; m_rr_rd = 0; m_terr = 0; m_ovf = 0;
            last_pulse_abs = -100;
            prev_err = 0;
            check("reset_outputs", int'(act), 0);
            return;
        end

        n_ref  += int'(bus.REF);
        n_wr   += int'(bus.WRITE);
        n_rd   += int'(bus.READ);
        n_wack += int'(bus.wr_ack);
        n_rack += int'(bus.rd_ack);
        if (bus.REF && first_ref_cyc < 0) first_ref_cyc = m_cyc;
        if (bus.WRITE) begin ulog.push_back(2); last_write_abs = abs_cyc; end
        if (bus.READ) ulog.push_back(3);
        if (seen_pulse) begin
            check("pulse_spacing_ge4", int'(abs_cyc - last_pulse_abs >= 4), 1);
            last_pulse_abs = abs_cyc;
        end
        if (bus.timeout_err && !prev_err) err_rise_abs = abs_cyc;
        prev_err = bus.timeout_err;
        if (track_max && int'(bus.ref_pending) > maxp) maxp = int'(bus.ref_pending);

        wr   = bus.wr_req;
        rd   = bus.rd_req;
        idle = bus.sm_idle;
        tick = (m_cyc % Refi) == Refi - 1;
        if (m_cmd == 0) st = 0;
        else if (m_age == 0) st = 1;
        else if (!m_started) st = 2;
        else st = 3;
        issue = (st == 1);
        done  = (st == 3) && idle;
        exp = {issue && m_cmd == 1, issue && m_cmd == 2, issue && m_cmd == 3,
               done && m_cmd == 2, done && m_cmd == 3, 4'(m_pend), 2'(st), m_terr, m_ovf};
        check("outputs", int'(act), int'(exp));

        npend = m_pend + (tick ? 1 : 0) - ((done && m_cmd == 1) ? 1 : 0);
        if (npend > MaxPp) npend = MaxPp;
`ifdef REF_POSTPONE_EN
        if (tick && m_pend == MaxPp) m_ovf = 1;
`else
        if (tick && npend > 1) m_ovf = 1;
`endif
        case (st)
            0: if (idle) begin
                nxt = pick(wr, rd, m_pend, m_rr_rd);
                if (nxt != 0) begin
                    m_cmd = nxt; m_age = 0; m_started = 0; m_waited = 0;
                    if (nxt != 1) m_rr_rd = !m_rr_rd;
                end
            end
            1: m_age = 1;
            2: begin
                m_waited++;
                if (!idle) m_started = 1;
                else if (m_waited == Tmo) begin m_terr = 1; m_cmd = 0; end
            end
            default: if (idle) m_cmd = 0;
        endcase
        m_pend = npend;
        m_cyc++;
    endtask

    task automatic drive_env();
        if (busy > 0) busy--;
        if (seen_pulse && !(stuck_wr && seen_write))
            busy = rand_busy ? int'($urandom_range(10, 1)) : 10;
        bus.sm_idle = (busy == 0);
        if (auto_drop && seen_wr_ack) bus.wr_req = 1'b0;
        if (auto_drop && seen_rd_ack) bus.rd_req = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        sample_and_check();
        @(posedge clk);
        #1;
        drive_env();
    endtask

    initial begin
        int s_ref, s_wr, s_rd, s_wack, s_rack, s_log;
        bit ok;
        bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.sm_idle = 1'b1;
        busy = 0; auto_drop = 1; stuck_wr = 0; rand_busy = 0; track_max = 0;
        n_ref = 0; n_wr = 0; n_rd = 0; n_wack = 0; n_rack = 0; abs_cyc = 0; maxp = 0;
        first_ref_cyc = -1; last_write_abs = -1; err_rise_abs = -1; last_pulse_abs = -100;
        repeat (3) step();
        rst = 1'b0;

        // Idle: one refresh per interval, first pulse the cycle after the grant.
        s_ref = n_ref; s_wack = n_wack; s_rack = n_rack;
        repeat (3 * Refi + 20) step();
        check("idle_ref_count", n_ref - s_ref, 3);
        check("idle_no_acks", n_wack + n_rack - s_wack - s_rack, 0);
        check("first_ref_cycle", first_ref_cyc, Refi + 1);
        check("idle_pending_drained", int'(bus.ref_pending), 0);

        // Both requesters: write, read, then write again.
        rand_busy = 1; s_log = ulog.size(); s_rack = n_rack;
        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin step(); ok = (n_rack > s_rack); end
        check("rr_read_acked", int'(ok), 1);
        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin step(); ok = (ulog.size() >= s_log + 3); end
        check("rr_third_grant_seen", int'(ok), 1);
        if (ulog.size() >= s_log + 3) begin
            check("rr_first_is_write", ulog[s_log], 2);
            check("rr_second_is_read", ulog[s_log + 1], 3);
            check("rr_third_is_write", ulog[s_log + 2], 2);
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step();
            if (!bus.wr_req && $urandom_range(5, 0) == 0) bus.wr_req = 1'b1;
            else if (bus.wr_req && $urandom_range(49, 0) == 0) bus.wr_req = 1'b0;
            if (!bus.rd_req && $urandom_range(5, 0) == 0) bus.rd_req = 1'b1;
            else if (bus.rd_req && $urandom_range(49, 0) == 0) bus.rd_req = 1'b0;
        end
        check("random_no_timeout", int'(bus.timeout_err), 0);

        // Continuous writes: refresh postponement behaviour.
        bus.wr_req = 1'b1; bus.rd_req = 1'b0; auto_drop = 0; rand_busy = 0;
        maxp = 0; track_max = 1; s_ref = n_ref; s_wr = n_wr;
        repeat (1500) step();
        track_max = 0;
`ifdef REF_POSTPONE_EN
        check("postpone_max_pending", maxp, MaxPp);
`else
        check("no_postpone_max_pending", maxp, 1);
`endif
        check("busy_ref_issued", int'(n_ref - s_ref > 0), 1);
        check("busy_writes_issued", int'(n_wr - s_wr > 20), 1);
        check("busy_no_overflow", int'(bus.ref_overflow), 0);

        // Command FSM never leaves idle after WRITE.
        bus.wr_req = 1'b0; auto_drop = 1;
        repeat (60) step();
        stuck_wr = 1; bus.wr_req = 1'b1; s_wack = n_wack;
        ok = 0;
        for (int i = 0; i < 1500 && !ok; i++) begin step(); ok = (err_rise_abs >= 0); end
        check("timeout_flagged", int'(ok), 1);
        check("timeout_latency", err_rise_abs - last_write_abs, Tmo + 1);
        s_wr = n_wr; ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin step(); ok = (n_wr > s_wr); end
        check("write_repulsed", int'(ok), 1);
        check("timeout_no_wr_ack", n_wack - s_wack, 0);
        check("timeout_sticky", int'(bus.timeout_err), 1);
        stuck_wr = 0; bus.wr_req = 1'b0;
        repeat (300) step();

        // Reset in the middle of a READ.
        s_rack = n_rack; s_rd = n_rd; bus.rd_req = 1'b1; ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin step(); ok = (n_rd > s_rd); end
        check("read_issued", int'(ok), 1);
        repeat (3) step();
        check("pre_reset_wait_done", int'(bus.sched_state), 3);
        rst = 1'b1;
        step();
        check("reset_no_rd_ack", n_rack - s_rack, 0);
        check("reset_clears_timeout", int'(bus.timeout_err), 0);
        step();
        rst = 1'b0;
        ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin step(); ok = (n_rack > s_rack); end
        check("read_after_reset", int'(ok), 1);
        check("single_rd_ack", n_rack - s_rack, 1);
        repeat (30) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
